mandelbrot_pixel_scheduler: RTL and testbench

- Initiator for the Mandelbrot calculator's pixel handshake.
- Walks an H_RES x V_RES frame in raster order and produces one fixed-point complex coordinate per pixel.
- Issues each coordinate to one calculator instance, collects the returned iteration count and writes it to the frame-buffer write port.
- Sits between the frame controller (frame_start/frame_done) and the calculator/frame buffer.

---
 rtl/mandelbrot_pixel_scheduler_pkg.sv | 23 ++
 rtl/mandelbrot_pixel_scheduler_if.sv | 34 +++
 rtl/mandelbrot_coord_stepper.sv | 94 +++++++++
 rtl/mandelbrot_pixel_scheduler.sv | 116 +++++++++++
 tb/tb_mandelbrot_pixel_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mandelbrot_pixel_scheduler_pkg.sv
// Shared definitions for the Mandelbrot pixel scheduler and calculator:
// fixed-point defaults, scheduler state encoding and a counter-width helper.
package mandelbrot_pkg;

  localparam int BIT_WIDTH_DEF       = 32;
  localparam int FLOAT_PRECISION_DEF = 24;
  localparam logic [BIT_WIDTH_DEF-1:0] FP_ONE = BIT_WIDTH_DEF'(1) << FLOAT_PRECISION_DEF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE,
    WRITE,
    DONE
  } sched_state_e;

  // A counter over n values needs at least one bit even when n == 1.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mandelbrot_pixel_scheduler_if.sv
// Calculator handshake and frame-buffer write port seen by the pixel scheduler.
interface mandelbrot_pixel_scheduler_if
  import mandelbrot_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int ADDR_WIDTH = 12
);

  logic [BIT_WIDTH-1:0]  calc_real;
  logic [BIT_WIDTH-1:0]  calc_imag;
  logic                  calc_start;
  logic                  calc_ready_for_input;
  logic                  calc_out_ready;
  logic [BIT_WIDTH-1:0]  calc_colour;
  logic                  pix_we;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [BIT_WIDTH-1:0]  pix_data;
  logic                  pix_ready;

  modport master (
    output calc_real, calc_imag, calc_start,
    input  calc_ready_for_input, calc_out_ready, calc_colour,
    output pix_we, pix_addr, pix_data,
    input  pix_ready
  );

  modport slave (
    input  calc_real, calc_imag, calc_start,
    output calc_ready_for_input, calc_out_ready, calc_colour,
    input  pix_we, pix_addr, pix_data,
    output pix_ready
  );

endinterface

// File: rtl/mandelbrot_coord_stepper.sv
// Raster walker: column/row counters, complex-plane accumulators and the
// linear frame-buffer address, advanced one pixel at a time.
module mandelbrot_coord_stepper
  import mandelbrot_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int H_RES      = 64,
  parameter int V_RES      = 48,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  input  logic [BIT_WIDTH-1:0]  x_min,
  input  logic [BIT_WIDTH-1:0]  y_max,
  input  logic [BIT_WIDTH-1:0]  step,
  output logic [BIT_WIDTH-1:0]  cur_re,
  output logic [BIT_WIDTH-1:0]  cur_im,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  output logic                  last_pixel
);

  localparam int COL_W = ctr_width(H_RES);
  localparam int ROW_W = ctr_width(V_RES);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [BIT_WIDTH-1:0]  re_q, re_d;
  logic [BIT_WIDTH-1:0]  im_q, im_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BIT_WIDTH-1:0]  x_min_q, x_min_d;
  logic [BIT_WIDTH-1:0]  step_q, step_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      addr_q  <= '0;
      x_min_q <= '0;
      step_q  <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      re_q    <= re_d;
      im_q    <= im_d;
      addr_q  <= addr_d;
      x_min_q <= x_min_d;
      step_q  <= step_d;
    end
  end

  // Coordinate updates wrap modulo 2^BIT_WIDTH; the address is a plain
  // counter because raster order makes row*H_RES+col increase by one.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    re_d    = re_q;
    im_d    = im_q;
    addr_d  = addr_q;
    x_min_d = x_min_q;
    step_d  = step_q;
    if (load) begin
      col_d   = '0;
      row_d   = '0;
      re_d    = x_min;
      im_d    = y_max;
      addr_d  = '0;
      x_min_d = x_min;
      step_d  = step;
    end else if (advance) begin
      addr_d = addr_q + 1'b1;
      if (col_q != COL_LAST) begin
        col_d = col_q + 1'b1;
        re_d  = re_q + step_q;
      end else begin
        col_d = '0;
        row_d = row_q + 1'b1;
        re_d  = x_min_q;
        im_d  = im_q - step_q;
      end
    end
  end

  assign cur_re     = re_q;
  assign cur_im     = im_q;
  assign pix_addr   = addr_q;
  assign last_pixel = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// Frame-level initiator: issues one coordinate per pixel to the calculator,
// captures the iteration count and writes it to the frame buffer.
module mandelbrot_pixel_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int BIT_WIDTH       = BIT_WIDTH_DEF,
  parameter int FLOAT_PRECISION = FLOAT_PRECISION_DEF,
  parameter int H_RES           = 64,
  parameter int V_RES           = 48,
  parameter int ADDR_WIDTH      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic [BIT_WIDTH-1:0] x_min,
  input  logic [BIT_WIDTH-1:0] y_max,
  input  logic [BIT_WIDTH-1:0] step,
  output logic                 busy,
  output logic                 frame_done,
  mandelbrot_pixel_scheduler_if.master bus
);

  if (FLOAT_PRECISION < 0 || FLOAT_PRECISION >= BIT_WIDTH) begin : g_bad_precision
    $error("FLOAT_PRECISION must lie in [0, BIT_WIDTH)");
  end
  if (H_RES < 1 || V_RES < 1 || (2 ** ADDR_WIDTH) < H_RES * V_RES) begin : g_bad_geometry
    $error("raster does not fit the frame-buffer address space");
  end

  sched_state_e         state_q, state_d;
  logic [BIT_WIDTH-1:0] colour_q, colour_d;
  logic                 load;
  logic                 advance;
  logic                 last_pixel;

  mandelbrot_coord_stepper #(
    .BIT_WIDTH  (BIT_WIDTH),
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_stepper (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .advance    (advance),
    .x_min      (x_min),
    .y_max      (y_max),
    .step       (step),
    .cur_re     (bus.calc_real),
    .cur_im     (bus.calc_imag),
    .pix_addr   (bus.pix_addr),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      colour_q <= colour_d;
    end
  end

  // WAIT_ACCEPT exists because calc_out_ready may still be high from the
  // previous pixel; only a ready drop proves the new job was taken.
  always_comb begin
    state_d  = state_q;
    colour_d = colour_q;
    load     = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.calc_ready_for_input) state_d = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (!bus.calc_ready_for_input) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.calc_ready_for_input && bus.calc_out_ready) begin
          colour_d = bus.calc_colour;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (bus.pix_ready) begin
          if (last_pixel) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy           = (state_q != IDLE);
  assign frame_done     = (state_q == DONE);
  assign bus.calc_start = (state_q == ISSUE);
  assign bus.pix_we     = (state_q == WRITE);
  assign bus.pix_data   = colour_q;

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Randomised bench for the pixel scheduler with a behavioural calculator,
// frame buffer and raster-order reference model.
module tb_mandelbrot_pixel_scheduler;

  localparam int BW   = 32;
  localparam int AW   = 12;
  localparam int HR   = 4;
  localparam int VR   = 2;
  localparam int NPIX = HR * VR;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic [BW-1:0] x_min = '0;
  logic [BW-1:0] y_max = '0;
  logic [BW-1:0] step = '0;
  logic          busy;
  logic          frame_done;

  mandelbrot_pixel_scheduler_if #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  mandelbrot_pixel_scheduler #(
    .BIT_WIDTH       (BW),
    .FLOAT_PRECISION (24),
    .H_RES           (HR),
    .V_RES           (VR),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .x_min       (x_min),
    .y_max       (y_max),
    .step        (step),
    .busy        (busy),
    .frame_done  (frame_done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // stimulus configuration
  bit cfg_hold_out = 1'b0;
  bit cfg_rand_bp = 1'b0;
  bit directed = 1'b0;
  int cfg_drop_max = 0;
  int stall_addr = -1;
  int stall_left = 0;
  bit req_start = 1'b0;
  bit poke_done = 1'b0;

  // reference model state
  logic [BW-1:0] exp_re[$];
  logic [BW-1:0] exp_im[$];
  int            exp_a[$];
  int            wq_addr[$];
  logic [BW-1:0] wq_data[$];
  bit exp_busy = 1'b0;
  bit exp_done = 1'b0;
  bit chk_lat = 1'b0;
  bit job_open = 1'b0;
  int writes_in_frame = 0;
  int frames_done = 0;
  int jidx = 0;

  // calculator model state
  int            cs = 0;
  int            drop_d = 0;
  int            cnt = 0;
  logic [BW-1:0] job_colour = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_calc_start"}, 64'(bus.calc_start), 64'd0);
    chk({tag, "_calc_real"}, 64'(bus.calc_real), 64'd0);
    chk({tag, "_calc_imag"}, 64'(bus.calc_imag), 64'd0);
    chk({tag, "_pix_we"}, 64'(bus.pix_we), 64'd0);
    chk({tag, "_pix_addr"}, 64'(bus.pix_addr), 64'd0);
    chk({tag, "_pix_data"}, 64'(bus.pix_data), 64'd0);
  endtask

  // Per-cycle process: sample at the falling edge, check, then drive the
  // inputs that the next rising edge will see and advance the model.
  initial begin
    bit            prev_stall;
    int            prev_addr;
    logic [BW-1:0] prev_data;
    bit            exp_done_next;
    bit            exp_busy_next;
    prev_stall = 1'b0;
    prev_addr = 0;
    prev_data = '0;
    bus.calc_ready_for_input = 1'b1;
    bus.calc_out_ready = 1'b0;
    bus.calc_colour = '0;
    bus.pix_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk_zero("reset");
        exp_re.delete(); exp_im.delete(); exp_a.delete();
        wq_addr.delete(); wq_data.delete();
        exp_busy = 1'b0; exp_done = 1'b0; chk_lat = 1'b0; job_open = 1'b0;
        writes_in_frame = 0; cs = 0; prev_stall = 1'b0;
        bus.calc_ready_for_input = 1'b1;
        bus.calc_out_ready = cfg_hold_out;
        bus.pix_ready = 1'b1;
        frame_start = 1'b0;
        req_start = 1'b0;
        continue;
      end

      chk("busy", 64'(busy), 64'(exp_busy));
      chk("frame_done", 64'(frame_done), 64'(exp_done));
      if (!exp_busy) begin
        chk("idle_calc_start", 64'(bus.calc_start), 64'd0);
        chk("idle_pix_we", 64'(bus.pix_we), 64'd0);
      end
      if (chk_lat) chk("start_latency", 64'(bus.calc_start), 64'd1);
      chk_lat = 1'b0;
      if (prev_stall) begin
        chk("stall_we", 64'(bus.pix_we), 64'd1);
        chk("stall_addr", 64'(bus.pix_addr), 64'(prev_addr));
        chk("stall_data", 64'(bus.pix_data), 64'(prev_data));
        chk("stall_no_issue", 64'(bus.calc_start), 64'd0);
      end

      frame_start = req_start || (poke_done && frame_done);
      if (poke_done && frame_done) poke_done = 1'b0;
      req_start = 1'b0;

      case (cs)
        0: bus.calc_ready_for_input = 1'b1;
        1: begin
          if (drop_d == 0) begin
            bus.calc_ready_for_input = 1'b0;
            if (!cfg_hold_out) bus.calc_out_ready = 1'b0;
            cs = 2;
          end else begin
            drop_d--;
          end
        end
        default: begin
          if (cnt <= 1) begin
            bus.calc_ready_for_input = 1'b1;
            bus.calc_out_ready = 1'b1;
            bus.calc_colour = job_colour;
            cs = 0;
          end else begin
            cnt--;
          end
        end
      endcase

      if (bus.calc_start && bus.calc_ready_for_input) begin
        chk("issue_while_pending", 64'(job_open), 64'd0);
        if (exp_re.size() == 0) begin
          chk("issue_extra", 64'd1, 64'd0);
        end else begin
          logic [BW-1:0] er, ei;
          int ea;
          er = exp_re.pop_front();
          ei = exp_im.pop_front();
          ea = exp_a.pop_front();
          chk($sformatf("calc_real_px%0d", ea), 64'(bus.calc_real), 64'(er));
          chk($sformatf("calc_imag_px%0d", ea), 64'(bus.calc_imag), 64'(ei));
          if (directed && jidx == 4) begin
            chk("row_wrap_real", 64'(bus.calc_real), 64'h0000_0000_FE00_0000);
            chk("row_wrap_imag", 64'(bus.calc_imag), 64'h0000_0000_00F0_0000);
          end
          if (directed && jidx == 7) begin
            chk("px7_real", 64'(bus.calc_real), 64'h0000_0000_FE30_0000);
            chk("px7_imag", 64'(bus.calc_imag), 64'h0000_0000_00F0_0000);
          end
          job_colour = directed ? 32'd10 : $urandom;
          wq_addr.push_back(ea);
          wq_data.push_back(job_colour);
        end
        jidx++;
        job_open = 1'b1;
        cs = 1;
        drop_d = $urandom_range(cfg_drop_max, 0);
        cnt = directed ? 5 : $urandom_range(6, 1);
      end

      if (stall_left > 0 && bus.pix_we && int'(bus.pix_addr) == stall_addr) begin
        bus.pix_ready = 1'b0;
        stall_left--;
      end else begin
        bus.pix_ready = cfg_rand_bp ? ($urandom_range(3, 0) != 0) : 1'b1;
      end
      prev_stall = bus.pix_we && !bus.pix_ready;
      prev_addr = int'(bus.pix_addr);
      prev_data = bus.pix_data;

      exp_done_next = 1'b0;
      if (bus.pix_we && bus.pix_ready) begin
        if (wq_addr.size() == 0) begin
          chk("write_extra", 64'd1, 64'd0);
        end else begin
          int            wa;
          logic [BW-1:0] wd;
          wa = wq_addr.pop_front();
          wd = wq_data.pop_front();
          chk("pix_addr", 64'(bus.pix_addr), 64'(wa));
          chk($sformatf("pix_data_px%0d", wa), 64'(bus.pix_data), 64'(wd));
        end
        job_open = 1'b0;
        writes_in_frame++;
        if (writes_in_frame == NPIX) exp_done_next = 1'b1;
      end

      exp_busy_next = exp_done ? 1'b0 : exp_busy;
      if (frame_start && !exp_busy) begin
        exp_busy_next = 1'b1;
        chk_lat = 1'b1;
        writes_in_frame = 0;
        jidx = 0;
        for (int r = 0; r < VR; r++) begin
          for (int c = 0; c < HR; c++) begin
            exp_re.push_back(x_min + BW'(c) * step);
            exp_im.push_back(y_max - BW'(r) * step);
            exp_a.push_back(r * HR + c);
          end
        end
      end
      if (exp_done) frames_done++;
      exp_busy = exp_busy_next;
      exp_done = exp_done_next;
    end
  end

  task automatic start_frame();
    @(posedge clk);
    #1 req_start = 1'b1;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n;
    n = 0;
    while (frames_done < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL %s: timeout, frames_done=%0d required %0d", tag, frames_done, target);
    end
  endtask

  task automatic wait_writes(input int target, input string tag);
    int n;
    n = 0;
    while (writes_in_frame < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (writes_in_frame < target) begin
      errors++;
      $display("FAIL %s: timeout, writes=%0d required %0d", tag, writes_in_frame, target);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_state");
    @(posedge clk);
    #1 rst = 1'b1;

    // Directed frame: stall at addr 2, ignored mid-frame start, start in DONE.
    x_min = 32'hFE00_0000;
    y_max = 32'h0100_0000;
    step = 32'h0010_0000;
    directed = 1'b1;
    stall_addr = 2;
    stall_left = 6;
    poke_done = 1'b1;
    start_frame();
    wait_writes(2, "frameA_mid");
    @(posedge clk);
    #1 x_min = 32'h1234_5678;
    req_start = 1'b1;
    wait_frames(1, "frameA_done");
    chk("frameA_writes", 64'(writes_in_frame), 64'd8);
    repeat (4) @(posedge clk);
    #1 chk("frameA_idle_after", 64'(busy), 64'd0);
    $display("frame A done: writes=%0d frames=%0d", writes_in_frame, frames_done);

    // Randomised frames: stale calc_out_ready held high, random backpressure.
    directed = 1'b0;
    cfg_hold_out = 1'b1;
    bus.calc_out_ready = 1'b1;
    cfg_rand_bp = 1'b1;
    cfg_drop_max = 2;
    for (int k = 0; k < 3; k++) begin
      x_min = $urandom;
      y_max = $urandom;
      step = $urandom;
      start_frame();
      wait_frames(2 + k, "rand_frame");
      $display("random frame %0d: x_min=%08h y_max=%08h step=%08h writes=%0d",
               k, x_min, y_max, step, writes_in_frame);
      repeat (2) @(posedge clk);
    end

    // Reset mid-frame at pixel 5, then restart from address 0.
    x_min = $urandom;
    start_frame();
    wait_writes(5, "reset_point");
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("async_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("no_done_after_reset", 64'(frames_done), 64'd4);
    start_frame();
    wait_frames(5, "restart_frame");
    chk("restart_writes", 64'(writes_in_frame), 64'd8);
    $display("restart frame done: writes=%0d frames=%0d", writes_in_frame, frames_done);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
